// File: rtl/shift_pkg.sv
// Shared encodings for the bit-serial shifter.
// Ops, FSM states and counter width.
package shift_pkg;
  localparam int SHAMT_BITS = 5;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
endpackage

// File: rtl/shift_step.sv
// One-bit shift of the working value.
// Reserved op passes the value through.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  always_comb begin
    dout = din;
    unique case (1'b1)
      (op == OP_SLL): dout = {din[WIDTH-2:0], 1'b0};
      (op == OP_SRL): dout = {1'b0, din[WIDTH-1:1]};
      (op == OP_SRA): dout = {din[WIDTH-1], din[WIDTH-1:1]};
      default:        dout = din;
    endcase
  end
endmodule

// File: rtl/shift_seq_unit.sv
// Bit-serial SLL/SRL/SRA: one position per clock,
// started by a pulse, finished with a done pulse.
module shift_seq_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] shamt_ext,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             op_err
);
  logic [1:0]            state_q, state_d;
  logic [SHAMT_BITS-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]      work_q, work_d;
  logic [1:0]            op_q, op_d;
  logic [WIDTH-1:0]      res_q, res_d;
  logic                  err_q, err_d;
  logic [WIDTH-1:0]      step_out;
  logic                  unused_hi;

  assign unused_hi = ^shamt_ext[WIDTH-1:SHAMT_BITS];

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op  (op_q),
    .din (work_q),
    .dout(step_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    op_d    = op_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d = data_in;
          op_d   = op;
          cnt_d  = shamt_ext[SHAMT_BITS-1:0];
          err_d  = 1'b0;
          if (op == OP_RSV) begin
            err_d   = 1'b1;
            res_d   = data_in;
            state_d = S_DONE;
          end else if (shamt_ext[SHAMT_BITS-1:0] == '0) begin
            res_d   = data_in;
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        // count is at least 1 here, so it never wraps
        work_d = step_out;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == SHAMT_BITS'(1)) begin
          res_d   = step_out;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      op_q    <= OP_SLL;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign busy   = (state_q == S_SHIFT);
  assign done   = (state_q == S_DONE);
  assign result = res_q;
  assign op_err = err_q;
endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed bench for shift_seq_unit: vector table
// plus reset, ignored-start and hold sequences.
module tb_shift_seq_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [31:0] shamt_ext;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        op_err;

  int checks = 0;
  int errors = 0;

  shift_seq_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .data_in  (data_in),
    .shamt_ext(shamt_ext),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .op_err   (op_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [31:0] shamt;
    logic [31:0] exp_res;
    logic        exp_err;
    int          exp_lat;
    int          exp_busy;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] d,
                        input logic [31:0] s, input bit mid_start,
                        output logic [31:0] r, output logic e,
                        output int lat, output int bcnt,
                        output int ovl);
    @(negedge clk);
    op = o; data_in = d; shamt_ext = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom);
    data_in = $urandom;
    shamt_ext = $urandom;
    lat = 0; bcnt = 0; ovl = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (mid_start && lat == 3) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
    if (busy && done) ovl = 1;
    r = result;
    e = op_err;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] r;
  logic        e;
  int          lat, bcnt, ovl;
  int          dn;

  initial begin
    vecs[0] = '{2'b00, 32'h0000_0001, 32'h0000_0004, 32'h0000_0010, 1'b0, 4, 4};
    vecs[1] = '{2'b10, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 31, 31};
    vecs[2] = '{2'b01, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 31, 31};
    vecs[3] = '{2'b01, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 32'hDEAD_BEEF, 1'b0, 0, 0};
    vecs[4] = '{2'b11, 32'h1234_5678, 32'd5, 32'h1234_5678, 1'b1, 0, 0};
    vecs[5] = '{2'b10, 32'hF000_0000, 32'd4, 32'hFF00_0000, 1'b0, 4, 4};
    vecs[6] = '{2'b01, 32'h8000_0000, 32'd1, 32'h4000_0000, 1'b0, 1, 1};
    vecs[7] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_003F, 32'h8000_0000, 1'b0, 31, 31};
    vecs[8] = '{2'b10, 32'h4000_0000, 32'd3, 32'h0800_0000, 1'b0, 3, 3};

    rst_n = 1'b0; start = 1'b0; op = 2'b00;
    data_in = '0; shamt_ext = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_err", 32'(op_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset in the middle of an SLL by 20
    @(negedge clk);
    op = 2'b00; data_in = 32'h1; shamt_ext = 32'd20; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("mid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy_async", 32'(busy), 32'd0);
    chk("mid_result_async", result, 32'd0);
    chk("mid_err_async", 32'(op_err), 32'd0);
    dn = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || busy) dn++;
    end
    chk("mid_no_done", 32'(dn), 32'd0);
    run_op(2'b00, 32'h1, 32'd1, 1'b0, r, e, lat, bcnt, ovl);
    chk("post_rst_res", r, 32'h2);
    chk("post_rst_lat", 32'(lat), 32'd1);

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].data, vecs[i].shamt, 1'b0,
             r, e, lat, bcnt, ovl);
      chk($sformatf("v%0d_res", i), r, vecs[i].exp_res);
      chk($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_busy", i), 32'(bcnt), 32'(vecs[i].exp_busy));
      chk($sformatf("v%0d_ovl", i), 32'(ovl), 32'd0);
    end

    // result and op_err persist in IDLE after the reserved op
    run_op(2'b11, 32'hCAFE_0001, 32'd0, 1'b0, r, e, lat, bcnt, ovl);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_result", result, 32'hCAFE_0001);
    chk("hold_err", 32'(op_err), 32'd1);
    chk("hold_done", 32'(done), 32'd0);

    // start pulsed while busy is ignored
    run_op(2'b01, 32'hFF00_0000, 32'd8, 1'b1, r, e, lat, bcnt, ovl);
    chk("ign_res", r, 32'h00FF_0000);
    chk("ign_lat", 32'(lat), 32'd8);
    chk("ign_err_clr", 32'(e), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("ign_idle", 32'(busy | done), 32'd0);

    // back-to-back: start presented as soon as done falls
    run_op(2'b00, 32'h3, 32'd2, 1'b0, r, e, lat, bcnt, ovl);
    chk("b2b_a", r, 32'hC);
    run_op(2'b01, 32'h30, 32'd4, 1'b0, r, e, lat, bcnt, ovl);
    chk("b2b_b", r, 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_seq_unit.md
# shift_seq_unit

Multi-cycle shifter that consumes the 32-bit zero-extended shift amount produced by the shamt extension stage and performs SLL, SRL or SRA one bit position per clock. It sits in the R-type execute path alongside the ALU; the datapath controller starts it with a single-cycle pulse and waits for a one-cycle completion pulse before writing the result back. It trades latency for area: no barrel network, only a one-bit step and a 5-bit down-counter.

## Interface
- WIDTH, 32, data and shift-amount width; only 32 is supported.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  shift operation: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
- data_in  input  32  operand (rt value).
- shamt_ext  input  32  zero-extended shift amount; bits [4:0] used, bits [31:5] ignored.
- busy  output  1  high while a shift is in progress (state SHIFT).
- done  output  1  one-cycle completion pulse.
- result  output  32  shifted value; held until the next accepted start.
- op_err  output  1  high with done when op = 11; cleared on next accepted start.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: on start = 1, latch data_in into the working register, op into the op register and shamt_ext[4:0] into count. Clear op_err. If op = 11: set op_err, go to DONE, working value = data_in. Else if count = 0: go to DONE. Else go to SHIFT.
- SHIFT: each clock, apply one step to the working register and decrement count.
  - SLL shifts in 0 at bit 0.
  - SRL shifts in 0 at bit 31.
  - SRA replicates bit 31.
  - When count = 1, the step completes and the FSM goes to DONE.
- DONE: done = 1 for exactly one cycle. result = working register. Return to IDLE.
- start in SHIFT or DONE is ignored; no queuing. data_in, op and shamt_ext changes after acceptance have no effect.
- Arithmetic: count is 5 bits and never wraps below 0. Shift amounts 0–31 only; 32 or more is unreachable because the upper bits are ignored.
- Reset, including mid-shift: state = IDLE, count = 0, working register = 0, result = 0, busy = 0, done = 0, op_err = 0. The in-flight operation is discarded with no done pulse.

## Timing
- Edge E0 samples start. done is high in the cycle following edge E(n), where n = shamt_ext[4:0]. For n = 0 or op = 11, that is the cycle right after E0.
- busy is high in the cycles after E0 through E(n−1), which is n cycles. busy is never high together with done.
- result updates on the same edge that raises done and is stable while done is high.
- Back-to-back: the earliest next accepted start is sampled on the edge that ends the done cycle, when the FSM is back in IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package, shift_pkg:
  - op encodings OP_SLL, OP_SRL, OP_SRA, OP_RSV.
  - state encodings S_IDLE, S_SHIFT, S_DONE, as a 2-bit localparam set.
  - SHAMT_BITS = 5.
- Sub-module shift_step: combinational one-bit shift of 32 bits selected by op. Instantiated once in the working-register feedback path.
- Top level: FSM, 5-bit down-counter, working/op/result registers.

## Test plan
- Reset mid-shift: start SLL, data 0x0000_0001, shamt 20; assert rst_n low 5 cycles later. Required: outputs zero asynchronously, no done pulse; a following SLL 1 of 0x1 gives 0x0000_0002.
- SLL: data 0x0000_0001, shamt_ext 0x0000_0004. Required: busy high 4 cycles, done 4 edges after start, result 0x0000_0010.
- SRA: data 0x8000_0000, shamt 31. Required: result 0xFFFF_FFFF, done 31 edges after start. The same operand with SRL gives 0x0000_0001.
- Zero shift and ignored upper bits: SRL, data 0xDEAD_BEEF, shamt_ext 0xFFFF_FFE0. Required: done in the cycle after E0, result 0xDEAD_BEEF, busy never high.
- Reserved op and ignored start: op 11 with data 0x1234_5678. Required: done and op_err high together next cycle, result 0x1234_5678. Also, a start pulsed while busy during an SRL 8 of 0xFF00_0000 is ignored and the result is 0x00FF_0000.
